output_merge: RTL and testbench

Clocked merge stage directly downstream of the two-input arbiter in the router output port. It issues arbitration requests on behalf of two input flit channels, consumes the arbiter's winner tokens, and forwards the winning input's flit(s) through a one-entry output register. Each request sent to the arbiter yields exactly one winner token, so one token is consumed per granted input, and a round holds one or two grants.

---
 rtl/output_merge_if.sv | 47 ++++
 rtl/output_merge.sv | 174 +++++++++++++++++
 tb/tb_output_merge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/output_merge_if.sv
// Bundle of the merge stage's flit inputs, arbiter request/token channels, output and error flag.
// The master modport is the merge stage; slave is the surrounding router and arbiter.
interface output_merge_if #(
   parameter int WIDTH = 9
);
   logic [WIDTH-1:0] in1_data;
   logic             in1_valid;
   logic             in1_ready;
   logic [WIDTH-1:0] in2_data;
   logic             in2_valid;
   logic             in2_ready;
   logic             arb_r1_valid;
   logic             arb_r1_ready;
   logic             arb_r2_valid;
   logic             arb_r2_ready;
   logic             arb_win_data;
   logic             arb_win_valid;
   logic             arb_win_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             err;

   modport master (
      input  in1_data, in1_valid, in2_data, in2_valid,
      output in1_ready, in2_ready,
      output arb_r1_valid, arb_r2_valid,
      input  arb_r1_ready, arb_r2_ready,
      input  arb_win_data, arb_win_valid,
      output arb_win_ready,
      output out_data, out_valid,
      input  out_ready,
      output err
   );

   modport slave (
      output in1_data, in1_valid, in2_data, in2_valid,
      input  in1_ready, in2_ready,
      input  arb_r1_valid, arb_r2_valid,
      output arb_r1_ready, arb_r2_ready,
      output arb_win_data, arb_win_valid,
      input  arb_win_ready,
      input  out_data, out_valid,
      output out_ready,
      input  err
   );
endinterface

// File: rtl/output_merge.sv
// Merge stage after the two-input arbiter: requests on behalf of two inputs, consumes winner tokens
// and forwards granted flits through a one-entry output register. Define MERGE_PKT_LOCK_EN to hold a grant until a tail flit.
module output_merge #(
   parameter int WIDTH = 9
) (
   input logic            clk,
   input logic            rst,
   output_merge_if.master bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_WIN = 2'd2,
      FWD      = 2'd3
   } state_t;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

   state_t           state_r, state_s;
   logic [1:0]       mask_r, mask_s;
   logic [1:0]       orig_r, orig_s;
   logic [1:0]       served_r, served_s;
   logic [1:0]       pending_r, pending_s;
   logic             sel_r, sel_s;
   logic             err_r, err_s;
   logic [WIDTH-1:0] out_data_r;
   logic             out_valid_r;

   logic             space_s;
   logic             acc_s;
   logic [WIDTH-1:0] acc_data_s;
   logic             grant_end_s;
   logic             in1_ready_s, in2_ready_s;
   logic             r1_valid_s, r2_valid_s;
   logic             win_ready_s;
   logic             bad_tok_s;

   // Output-register space, selected-input accept and end-of-grant detection.
   always_comb begin
      space_s    = !out_valid_r || bus.out_ready;
      acc_data_s = sel_r ? bus.in2_data : bus.in1_data;
      if (state_r == FWD) begin
         in1_ready_s = !sel_r && space_s;
         in2_ready_s = sel_r && space_s;
      end else begin
         in1_ready_s = 1'b0;
         in2_ready_s = 1'b0;
      end
      acc_s = (bus.in1_valid && in1_ready_s) || (bus.in2_valid && in2_ready_s);
`ifdef MERGE_PKT_LOCK_EN
      grant_end_s = acc_s && acc_data_s[WIDTH-1];
`else
      grant_end_s = acc_s;
`endif
   end

   // Next-state and arbiter-side handshake decode.
   always_comb begin
      state_s     = state_r;
      mask_s      = mask_r;
      orig_s      = orig_r;
      served_s    = served_r;
      pending_s   = pending_r;
      sel_s       = sel_r;
      err_s       = err_r;
      r1_valid_s  = 1'b0;
      r2_valid_s  = 1'b0;
      win_ready_s = 1'b0;
      bad_tok_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.in1_valid || bus.in2_valid) begin
               mask_s    = {bus.in2_valid, bus.in1_valid};
               orig_s    = {bus.in2_valid, bus.in1_valid};
               served_s  = 2'b00;
               pending_s = popcount2({bus.in2_valid, bus.in1_valid});
               state_s   = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            r1_valid_s = mask_r[0];
            r2_valid_s = mask_r[1];
            mask_s = mask_r & ~{r2_valid_s && bus.arb_r2_ready, r1_valid_s && bus.arb_r1_ready};
            if (mask_s == 2'b00) begin
               state_s = WAIT_WIN;
            end else begin
               state_s = REQ;
            end
         end
         WAIT_WIN: begin
            win_ready_s = 1'b1;
            // A token for an input never requested, already served, or with nothing pending is dropped.
            bad_tok_s = !orig_r[bus.arb_win_data] || served_r[bus.arb_win_data] ||
                        (pending_r == 2'd0);
            if (bus.arb_win_valid) begin
               if (bad_tok_s) begin
                  err_s   = 1'b1;
                  state_s = IDLE;
               end else begin
                  sel_s                     = bus.arb_win_data;
                  served_s[bus.arb_win_data] = 1'b1;
                  pending_s                 = pending_r - 2'd1;
                  state_s                   = FWD;
               end
            end else begin
               state_s = WAIT_WIN;
            end
         end
         FWD: begin
            if (grant_end_s) begin
               if (pending_r != 2'd0) begin
                  state_s = WAIT_WIN;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = FWD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control-state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         mask_r    <= 2'b00;
         orig_r    <= 2'b00;
         served_r  <= 2'b00;
         pending_r <= 2'd0;
         sel_r     <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         mask_r    <= mask_s;
         orig_r    <= orig_s;
         served_r  <= served_s;
         pending_r <= pending_s;
         sel_r     <= sel_s;
         err_r     <= err_s;
      end
   end

   // One-entry output register; a drain and a load in the same cycle keeps it full.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_r  <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
      end else if (acc_s) begin
         out_data_r  <= acc_data_s;
         out_valid_r <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign bus.in1_ready     = in1_ready_s;
   assign bus.in2_ready     = in2_ready_s;
   assign bus.arb_r1_valid  = r1_valid_s;
   assign bus.arb_r2_valid  = r2_valid_s;
   assign bus.arb_win_ready = win_ready_s;
   assign bus.out_data      = out_data_r;
   assign bus.out_valid     = out_valid_r;
   assign bus.err           = err_r;
endmodule

// File: tb/tb_output_merge.sv
// Directed bench for output_merge: queue-fed input sources and arbiter token source, negedge monitor.
module tb_output_merge;
   localparam int W = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   output_merge_if #(.WIDTH(W)) bus ();
   output_merge #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.master));

   always #5 clk = ~clk;

   logic [W-1:0] in1_q[$];
   logic [W-1:0] in2_q[$];
   logic         tok_q[$];
   logic [W-1:0] out_q[$];
   logic         in1_tk = 1'b0, in2_tk = 1'b0, tok_tk = 1'b0;
   int           tok_cnt = 0;
   logic         r2_seen = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Handshakes complete at the next posedge; record them mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.in1_valid && bus.in1_ready) in1_tk = 1'b1;
         if (bus.in2_valid && bus.in2_ready) in2_tk = 1'b1;
         if (bus.arb_win_valid && bus.arb_win_ready) begin
            tok_tk = 1'b1;
            tok_cnt++;
         end
         if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
         if (bus.arb_r2_valid) r2_seen = 1'b1;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
      if (in1_tk) begin void'(in1_q.pop_front()); in1_tk = 1'b0; end
      if (in2_tk) begin void'(in2_q.pop_front()); in2_tk = 1'b0; end
      if (tok_tk) begin void'(tok_q.pop_front()); tok_tk = 1'b0; end
      bus.in1_valid     = (in1_q.size() > 0);
      bus.in1_data      = (in1_q.size() > 0) ? in1_q[0] : 9'h000;
      bus.in2_valid     = (in2_q.size() > 0);
      bus.in2_data      = (in2_q.size() > 0) ? in2_q[0] : 9'h000;
      bus.arb_win_valid = (tok_q.size() > 0);
      bus.arb_win_data  = (tok_q.size() > 0) ? tok_q[0] : 1'b0;
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_env();
      in1_q.delete(); in2_q.delete(); tok_q.delete(); out_q.delete();
      in1_tk = 1'b0; in2_tk = 1'b0; tok_tk = 1'b0;
      tok_cnt = 0; r2_seen = 1'b0;
      bus.in1_valid = 1'b0; bus.in2_valid = 1'b0; bus.arb_win_valid = 1'b0;
      bus.in1_data = 9'h000; bus.in2_data = 9'h000; bus.arb_win_data = 1'b0;
   endtask

   task automatic do_reset();
      clear_env();
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      clear_env();
      bus.out_ready = 1'b1;
   endtask

   task automatic chk_idle(input string tag);
      chk(tag, {27'd0, bus.in1_ready, bus.in2_ready, bus.arb_win_ready, bus.arb_r1_valid,
                bus.arb_r2_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.arb_r1_ready = 1'b1;
      bus.arb_r2_ready = 1'b1;
      bus.out_ready    = 1'b1;
      clear_env();
      do_reset();

      // Reset state
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data", {23'd0, bus.out_data}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk_idle("rst_idle");

      // Single request, cycle by cycle
      in1_q.push_back(9'h0AA);
      tok_q.push_back(1'b0);
      step();
      chk("s_c0_r1", {31'd0, bus.arb_r1_valid}, 32'd0);
      step();
      chk("s_c1_r1", {31'd0, bus.arb_r1_valid}, 32'd1);
      chk("s_c1_r2", {31'd0, bus.arb_r2_valid}, 32'd0);
      step();
      chk("s_win_ready", {31'd0, bus.arb_win_ready}, 32'd1);
      step();
      chk("s_in1_ready", {31'd0, bus.in1_ready}, 32'd1);
      chk("s_in2_ready", {31'd0, bus.in2_ready}, 32'd0);
      step();
      chk("s_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("s_out_data", {23'd0, bus.out_data}, 32'h0AA);
      run(6);
      chk("s_nout", out_q.size(), 32'd1);
      if (out_q.size() > 0) chk("s_out0", {23'd0, out_q[0]}, 32'h0AA);
      chk("s_r2_seen", {31'd0, r2_seen}, 32'd0);
      chk("s_tokens", tok_cnt, 32'd1);
      chk("s_pending", {30'd0, dut.pending_r}, 32'd0);
      chk_idle("s_idle");

      // Dual request, tokens 1 then 0
      do_reset();
      in1_q.push_back(9'b101010101);
      in2_q.push_back(9'b000011111);
      tok_q.push_back(1'b1);
      tok_q.push_back(1'b0);
      run(15);
      chk("d_nout", out_q.size(), 32'd2);
      if (out_q.size() > 1) begin
         chk("d_out0", {23'd0, out_q[0]}, {23'd0, 9'b000011111});
         chk("d_out1", {23'd0, out_q[1]}, {23'd0, 9'b101010101});
      end
      chk("d_tokens", tok_cnt, 32'd2);
      chk_idle("d_idle");

      // Backpressure with the second grant stuck behind a full register
      do_reset();
      bus.out_ready = 1'b0;
      in1_q.push_back(9'h101);
      in2_q.push_back(9'h102);
      tok_q.push_back(1'b0);
      tok_q.push_back(1'b1);
      run(7);
      chk("b_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("b_in1_ready", {31'd0, bus.in1_ready}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("b_hold_data", {23'd0, bus.out_data}, 32'h101);
         chk("b_in2_ready", {31'd0, bus.in2_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("b_in2_ready_drain", {31'd0, bus.in2_ready}, 32'd1);
      run(6);
      chk("b_nout", out_q.size(), 32'd2);
      if (out_q.size() > 1) begin
         chk("b_out0", {23'd0, out_q[0]}, 32'h101);
         chk("b_out1", {23'd0, out_q[1]}, 32'h102);
      end
      chk("b_out_valid_end", {31'd0, bus.out_valid}, 32'd0);

      // Packet lock vs per-flit grants
      do_reset();
      in1_q.push_back(9'h001);
      in1_q.push_back(9'h002);
      in1_q.push_back(9'h103);
      in2_q.push_back(9'h155);
      tok_q.push_back(1'b0);
      tok_q.push_back(1'b1);
`ifndef MERGE_PKT_LOCK_EN
      tok_q.push_back(1'b0);
      tok_q.push_back(1'b0);
`endif
      run(30);
      chk("p_nout", out_q.size(), 32'd4);
      if (out_q.size() > 3) begin
`ifdef MERGE_PKT_LOCK_EN
         chk("p_out0", {23'd0, out_q[0]}, 32'h001);
         chk("p_out1", {23'd0, out_q[1]}, 32'h002);
         chk("p_out2", {23'd0, out_q[2]}, 32'h103);
         chk("p_out3", {23'd0, out_q[3]}, 32'h155);
`else
         chk("p_out0", {23'd0, out_q[0]}, 32'h001);
         chk("p_out1", {23'd0, out_q[1]}, 32'h155);
         chk("p_out2", {23'd0, out_q[2]}, 32'h002);
         chk("p_out3", {23'd0, out_q[3]}, 32'h103);
`endif
      end
`ifdef MERGE_PKT_LOCK_EN
      chk("p_tokens", tok_cnt, 32'd2);
`else
      chk("p_tokens", tok_cnt, 32'd4);
`endif

      // Protocol error: token names an input that never requested
      do_reset();
      in1_q.push_back(9'h0AA);
      tok_q.push_back(1'b1);
      run(4);
      chk("e_err", {31'd0, bus.err}, 32'd1);
      chk_idle("e_idle");
      in1_q.delete();
      bus.in1_valid = 1'b0;
      run(5);
      chk("e_err_sticky", {31'd0, bus.err}, 32'd1);
      chk("e_nout", out_q.size(), 32'd0);
      chk("e_tokens", tok_cnt, 32'd1);
      chk("e_out_valid", {31'd0, bus.out_valid}, 32'd0);

      // Reset while forwarding with a held flit
      do_reset();
      bus.out_ready = 1'b0;
      in1_q.push_back(9'h0F0);
      in2_q.push_back(9'h0F1);
      tok_q.push_back(1'b0);
      tok_q.push_back(1'b1);
      run(8);
      chk("r_pre_valid", {31'd0, bus.out_valid}, 32'd1);
      clear_env();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("r_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk_idle("r_idle");
      chk("r_pending", {30'd0, dut.pending_r}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
